transmit_control: RTL and testbench
===================================

# transmit_control

UART transmit path of the SPART: accepts bytes from the processor bus into an 8-entry transmit FIFO and serialises them on `txd` as 8N1 frames, one bit per `baud` tick. It is the transmit-side counterpart of `receive_control` and shares its `baud` enable and I/O address decode. `tbr` tells the processor when another byte may be written.

## Interface
Parameters:
- `DATA_W`, 8: bits per character.
- `FIFO_DEPTH`, 8: transmit FIFO entries; power of two.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud`  in  1  one-`clk`-wide enable, once per bit period.
- `iocs`  in  1  chip select.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  register select; 2'b00 = data register.
- `bus_out`  in  DATA_W  byte from the processor.
- `tbr`  out  1  transmit buffer ready; 1 = FIFO not full.
- `tx_busy`  out  1  1 while a frame is on the line.
- `txd`  out  1  serial output, idle high, registered.

## Operation
- Push: `iocs & ~iorw & (ioaddr==2'b00)` in a cycle with `tbr`=1 writes `bus_out` to the FIFO tail.
- Push while full (`tbr`=0) is dropped silently; the FIFO and pointers stay unchanged.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits with a wrap bit. Full when indices are equal and wrap bits differ; empty when both are equal.
- Frame: start bit 0, then data LSB first, then one stop bit 1. Each bit lasts exactly one baud period, giving 10 baud periods per byte.
- FSM states are IDLE, START, DATA and STOP. All transitions occur only on cycles with `baud`=1.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, drive `txd`<=0 and go to START. Otherwise hold, with `txd`=1.
  - START to DATA: `txd`<=shift[0], bit counter <=0.
  - DATA: shift right and increment the counter. When the counter reaches DATA_W-1, drive `txd`<=1 and go to STOP. Otherwise `txd`<=next bit.
  - STOP: if the FIFO is not empty, pop, drive `txd`<=0 and go to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- `tx_busy` = state != IDLE.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged. A push to an empty FIFO cannot pop in that same cycle; that byte is popped at the next eligible `baud`.
- Reads (`iorw`=1) and other `ioaddr` values have no effect.

## Timing
- Reset values: `txd`=1, `tbr`=1, `tx_busy`=0, state IDLE, FIFO empty, pointers 0, shift register 0, bit counter 0.
- Reset asserted mid-frame: `txd` returns to 1 immediately (asynchronously), queued bytes are discarded, and the frame is abandoned.
- `tbr` is combinational from the pointers. It falls in the cycle after the push that fills the FIFO and rises in the cycle after the pop that frees an entry.
- Start-bit latency: the start bit begins at the first `baud` tick strictly after the push cycle, plus one `clk` for the `txd` register.
- `txd` changes only in the cycle following a `baud` tick.
- `baud` held high continuously is legal: one bit per `clk`.

## Structure
- Shared package `spart_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - `IOADDR_DATA` = 2'b00.
  - `UART_DATA_W` = 8.
  - Also shared with `receive_control`.
- Sub-module `tx_shift_register`: parallel load, shift right on enable, serial LSB out.
- FIFO storage and pointers, FSM, and bit counter live in the top module.

## Test plan
- Reset, then idle for 50 `baud` ticks with no writes -> `txd`=1, `tbr`=1 and `tx_busy`=0 throughout.
- Write 0xA5 -> `txd` carries the sequence 0,1,0,1,0,0,1,0,1,1, one bit per baud period, then stays 1; `tx_busy` is high for exactly 10 periods.
- Write 0x00 then 0xFF in consecutive cycles -> two frames with no idle gap, bit pattern 0,00000000,1,0,11111111,1.
- Write 9 bytes 0x01–0x09 with `baud` stalled low:
  - `tbr` goes low after the 8th byte (0x08), the 9th write is dropped, and `tx_busy` stays 0 while `baud` is held low.
  - Once `baud` resumes, the popped head 0x01 transmits, `tbr` returns to 1 after that first pop, and the remaining frames 0x02–0x08 follow back-to-back.
  - 0x09 never appears on `txd`.
- Write 0x3C, then pulse `rst_n` low during data bit 4 -> `txd`=1 immediately, the FIFO is empty, and no further frame starts.
- Write with `iorw`=1, with `ioaddr`=2'b01, and with `iocs`=0 -> no frame is sent and the FIFO remains empty.

Source files
------------

// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared SPART types and constants
// Used by transmit_control and receive_control.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] IOADDR_DATA = 2'b00;
  localparam int         UART_DATA_W = 8;

endpackage

// File: rtl/tx_shift_register.sv
// rtl/tx_shift_register.sv - parallel-load, shift-right serialiser
// Ports: clk, rst_n (async, active-low); load/data_in capture a character;
// shift_en shifts right with zero fill; serial_out is the current LSB and
// next_out the bit that becomes the LSB after the next shift.
module tx_shift_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] data_in,
  output logic         serial_out,
  output logic         next_out
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= data_in;
    end else if (shift_en) begin
      q <= {1'b0, q[W-1:1]};
    end
  end

  assign serial_out = q[0];
  assign next_out   = q[1];

endmodule

// File: rtl/transmit_control.sv
// rtl/transmit_control.sv - SPART transmit FIFO and 8N1 serialiser
// Ports: clk, rst_n (async, active-low); baud bit-period enable; iocs/iorw/
// ioaddr/bus_out processor write port; tbr = FIFO not full; tx_busy = frame
// on the line; txd registered serial output, idle high.
module transmit_control
  import spart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  input  logic [DATA_W-1:0] bus_out,
  output logic              tbr,
  output logic              tx_busy,
  output logic              txd
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);

  // FIFO: pointers carry an extra wrap bit to tell full from empty.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign tbr   = ~full;
  assign push  = iocs & ~iorw & (ioaddr == IOADDR_DATA) & ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus_out;
  end

  // Serialiser datapath
  logic load, shift_en, sr_bit0, sr_bit1;

  tx_shift_register #(.W(DATA_W)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .shift_en  (shift_en),
    .data_in   (mem[rd_ptr[AW-1:0]]),
    .serial_out(sr_bit0),
    .next_out  (sr_bit1)
  );

  // FSM, bit counter and txd register
  tx_state_t        state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic             txd_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    txd_n     = txd;
    pop       = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    if (baud) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            txd_n = 1'b1;
          end
        end
        START: begin
          txd_n     = sr_bit0;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
        DATA: begin
          shift_en  = 1'b1;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            // bit that becomes the LSB after this shift
            txd_n = sr_bit1;
          end
        end
        STOP: begin
          // pop straight into the next start bit: no idle gap between frames
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            txd_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_transmit_control.sv
// tb/tb_transmit_control.sv - scoreboard bench for transmit_control
module tb_transmit_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] bus_out = 8'h00;
  logic       tbr, tx_busy, txd;

  transmit_control #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .baud   (baud),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .bus_out(bus_out),
    .tbr    (tbr),
    .tx_busy(tx_busy),
    .txd    (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // baud generator
  logic baud_en = 1'b0;
  int   baud_div = 4;
  int   div_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (baud_en) begin
        div_cnt++;
        if (div_cnt >= baud_div) begin
          baud = 1'b1;
          div_cnt = 0;
        end else begin
          baud = 1'b0;
        end
      end else begin
        baud = 1'b0;
        div_cnt = 0;
      end
    end
  end

  // scoreboard and line monitor
  logic [7:0] sb[$];
  logic       baud_prev = 1'b0;
  int         mon_phase = 0;
  int         mon_bitidx = 0;
  logic [7:0] mon_byte = 8'h00;
  int         frames = 0, starts = 0, busy_periods = 0, gap = 0, gap_frames = 0;

  always @(posedge clk) baud_prev <= baud;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_phase  = 0;
      mon_bitidx = 0;
      gap        = 0;
      sb.delete();
    end else if (baud_prev) begin
      if (tx_busy) busy_periods++;
      case (mon_phase)
        0: begin
          if (txd == 1'b0) begin
            mon_phase  = 1;
            mon_bitidx = 0;
            starts++;
            if (gap != 0) gap_frames++;
          end else begin
            gap++;
          end
        end
        1: begin
          mon_byte[mon_bitidx] = txd;
          mon_bitidx++;
          if (mon_bitidx == 8) mon_phase = 2;
        end
        default: begin
          check_eq("stop_bit", txd, 1);
          if (sb.size() == 0) begin
            check_eq("unexpected_frame", mon_byte, 32'hFFFF_FFFF);
          end else begin
            check_eq("frame_byte", mon_byte, sb.pop_front());
          end
          frames++;
          gap       = 0;
          mon_phase = 0;
        end
      endcase
    end
  end

  task automatic bus_write(input logic cs, input logic rw, input logic [1:0] a,
                           input logic [7:0] d, input bit accepted);
    iocs    = cs;
    iorw    = rw;
    ioaddr  = a;
    bus_out = d;
    if (accepted) sb.push_back(d);
    @(negedge clk);
    iocs = 1'b0;
    iorw = 1'b0;
    ioaddr = 2'b00;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || tx_busy || mon_phase != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) check_eq("wait_done_timeout", 1, 0);
  endtask

  int f0, b0, s0, g0, viol, n;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_txd", txd, 1);
    check_eq("reset_tbr", tbr, 1);
    check_eq("reset_busy", tx_busy, 0);

    // idle for 50 baud ticks
    baud_div = 4;
    baud_en  = 1'b1;
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1 || tbr !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    check_eq("idle_50_ticks", viol, 0);

    // single frame 0xA5
    f0 = frames; b0 = busy_periods;
    bus_write(1, 0, 2'b00, 8'hA5, 1);
    wait_done(2000);
    check_eq("a5_frames", frames - f0, 1);
    check_eq("a5_busy_periods", busy_periods - b0, 10);
    repeat (12) @(negedge clk);
    check_eq("a5_idle_after", txd, 1);

    // back-to-back 0x00, 0xFF with baud held high
    baud_div = 1;
    f0 = frames; b0 = busy_periods; g0 = gap_frames;
    bus_write(1, 0, 2'b00, 8'h00, 1);
    bus_write(1, 0, 2'b00, 8'hFF, 1);
    wait_done(500);
    check_eq("b2b_frames", frames - f0, 2);
    check_eq("b2b_busy_periods", busy_periods - b0, 20);
    check_eq("b2b_gapped_frames", gap_frames - g0, 1);

    // fill FIFO with baud stalled
    baud_en  = 1'b0;
    baud_div = 4;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("tbr_before_wr%0d", i + 1), tbr, (i < 8) ? 1 : 0);
      bus_write(1, 0, 2'b00, 8'(i + 1), i < 8);
    end
    check_eq("full_tbr", tbr, 0);
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) viol++;
    end
    check_eq("stalled_busy", viol, 0);
    f0 = frames; g0 = gap_frames;
    baud_en = 1'b1;
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_pop_seen", n < 100, 1);
    check_eq("tbr_after_pop", tbr, 1);
    wait_done(5000);
    check_eq("full_frames", frames - f0, 8);
    check_eq("full_gapped_frames", gap_frames - g0, 1);

    // reset during data bit 4 of 0x3C
    bus_write(1, 0, 2'b00, 8'h3C, 1);
    n = 0;
    while (!(mon_phase == 1 && mon_bitidx == 5) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reach_bit4", n < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", tx_busy, 0);
    check_eq("rst_tbr", tbr, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts;
    repeat (120) @(negedge clk);
    check_eq("rst_no_restart", starts - s0, 0);
    check_eq("rst_txd_idle", txd, 1);

    // ignored accesses
    baud_en = 1'b0;
    f0 = frames; s0 = starts;
    bus_write(1, 1, 2'b00, 8'h55, 0);
    bus_write(1, 0, 2'b01, 8'h66, 0);
    bus_write(0, 0, 2'b00, 8'h77, 0);
    check_eq("ign_tbr", tbr, 1);
    baud_en = 1'b1;
    viol = 0;
    repeat (120) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || txd !== 1'b1) viol++;
    end
    check_eq("ign_no_frame", viol, 0);
    check_eq("ign_starts", starts - s0, 0);
    check_eq("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
